// File: rtl/fetch_queue.sv
// Fetch queue: turns PC generator addresses into in-order instruction-memory requests and
// buffers the returned words with their PC for decode, squashing wrong-path work on Flush.
module fetch_queue #(
  parameter int XLEN  = 32,
  parameter int ILEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [XLEN-1:0] PC,
  input  logic            Valid,
  input  logic            Flush,
  output logic            PC_stall,
  output logic            IMEM_req,
  output logic [XLEN-1:0] IMEM_addr,
  input  logic            IMEM_gnt,
  input  logic            IMEM_rvalid,
  input  logic [ILEN-1:0] IMEM_rdata,
  output logic [ILEN-1:0] Inst,
  output logic [XLEN-1:0] Inst_PC,
  output logic            Inst_valid,
  input  logic            Inst_ready
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] ZERO_C  = {CW{1'b0}};

  logic            skid_v_r;
  logic [XLEN-1:0] skid_pc_r;
  logic [XLEN-1:0] pc_mem_r   [DEPTH];
  logic [ILEN-1:0] inst_mem_r [DEPTH];
  logic [AW-1:0]   head_r;
  logic [AW-1:0]   tail_r;
  logic [AW-1:0]   fill_r;
  logic [CW-1:0]   alloc_cnt_r;
  logic [CW-1:0]   pend_cnt_r;
  logic [CW-1:0]   discard_cnt_r;

  logic            src_valid_s;
  logic [XLEN-1:0] src_pc_s;
  logic [CW:0]     occupancy_s;
  logic            has_credit_s;
  logic            head_filled_s;
  logic            issue_s;
  logic            pop_s;
  logic            rv_drop_s;
  logic            rv_fill_s;
  logic            rv_used_s;
  logic            skid_v_next_s;
  logic [XLEN-1:0] skid_pc_next_s;
  logic [CW-1:0]   alloc_cnt_next_s;
  logic [CW-1:0]   pend_cnt_next_s;
  logic [CW-1:0]   discard_cnt_next_s;

  // Request, stall and decode-side handshake (combinational by design).
  always_comb begin
    src_valid_s = skid_v_r | Valid;
    if (skid_v_r) begin
      src_pc_s = skid_pc_r;
    end else begin
      src_pc_s = PC;
    end
    // Responses still owed to flushed requests consume credits like live entries.
    occupancy_s   = {1'b0, alloc_cnt_r} + {1'b0, discard_cnt_r};
    has_credit_s  = (occupancy_s < {1'b0, DEPTH_C});
    IMEM_req      = ~RST & src_valid_s & ~Flush & has_credit_s;
    IMEM_addr     = src_pc_s;
    issue_s       = IMEM_req & IMEM_gnt;
    PC_stall      = ~RST & ~Flush & ((Valid & ~skid_v_r & ~issue_s) | (skid_v_r & ~issue_s));
    head_filled_s = (alloc_cnt_r != pend_cnt_r);
    Inst_valid    = ~RST & head_filled_s & ~Flush;
    Inst          = inst_mem_r[head_r];
    Inst_PC       = pc_mem_r[head_r];
    pop_s         = Inst_valid & Inst_ready;
    rv_drop_s     = IMEM_rvalid & (discard_cnt_r != ZERO_C);
    rv_fill_s     = IMEM_rvalid & (discard_cnt_r == ZERO_C) & (pend_cnt_r != ZERO_C);
    rv_used_s     = rv_drop_s | rv_fill_s;
  end

  // Next-state for skid register and occupancy counters.
  always_comb begin
    skid_v_next_s  = 1'b0;
    skid_pc_next_s = skid_pc_r;
    if (Flush) begin
      skid_v_next_s  = 1'b0;
      skid_pc_next_s = skid_pc_r;
    end else if (skid_v_r & ~issue_s) begin
      skid_v_next_s  = 1'b1;
      skid_pc_next_s = skid_pc_r;
    end else if (Valid & ~(issue_s & ~skid_v_r)) begin
      skid_v_next_s  = 1'b1;
      skid_pc_next_s = PC;
    end else begin
      skid_v_next_s  = 1'b0;
      skid_pc_next_s = skid_pc_r;
    end

    alloc_cnt_next_s   = alloc_cnt_r;
    pend_cnt_next_s    = pend_cnt_r;
    discard_cnt_next_s = discard_cnt_r;
    if (Flush) begin
      alloc_cnt_next_s   = ZERO_C;
      pend_cnt_next_s    = ZERO_C;
      discard_cnt_next_s = discard_cnt_r + pend_cnt_r - CW'(rv_used_s);
    end else begin
      alloc_cnt_next_s   = alloc_cnt_r + CW'(issue_s) - CW'(pop_s);
      pend_cnt_next_s    = pend_cnt_r + CW'(issue_s) - CW'(rv_fill_s);
      discard_cnt_next_s = discard_cnt_r - CW'(rv_drop_s);
    end
  end

  // Control state: skid, queue pointers and counters.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      skid_v_r      <= 1'b0;
      skid_pc_r     <= {XLEN{1'b0}};
      head_r        <= {AW{1'b0}};
      tail_r        <= {AW{1'b0}};
      fill_r        <= {AW{1'b0}};
      alloc_cnt_r   <= ZERO_C;
      pend_cnt_r    <= ZERO_C;
      discard_cnt_r <= ZERO_C;
    end else begin
      skid_v_r      <= skid_v_next_s;
      skid_pc_r     <= skid_pc_next_s;
      alloc_cnt_r   <= alloc_cnt_next_s;
      pend_cnt_r    <= pend_cnt_next_s;
      discard_cnt_r <= discard_cnt_next_s;
      if (Flush) begin
        head_r <= {AW{1'b0}};
        tail_r <= {AW{1'b0}};
        fill_r <= {AW{1'b0}};
      end else begin
        if (issue_s) begin
          tail_r <= tail_r + AW'(1'b1);
        end
        if (rv_fill_s) begin
          fill_r <= fill_r + AW'(1'b1);
        end
        if (pop_s) begin
          head_r <= head_r + AW'(1'b1);
        end
      end
    end
  end

  // Entry storage: PC written on issue, instruction written when its response returns.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_r[i]   <= {XLEN{1'b0}};
        inst_mem_r[i] <= {ILEN{1'b0}};
      end
    end else begin
      if (issue_s) begin
        pc_mem_r[tail_r] <= src_pc_s;
      end
      if (rv_fill_s & ~Flush) begin
        inst_mem_r[fill_r] <= IMEM_rdata;
      end
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios plus random traffic, checked every cycle against
// a queue-based reference model with a PC generator and in-order memory model.
module tb_fetch_queue;
  localparam int XLEN  = 32;
  localparam int ILEN  = 32;
  localparam int DEPTH = 4;

  logic            CLK, RST;
  logic [XLEN-1:0] PC;
  logic            Valid, Flush;
  logic            PC_stall, IMEM_req;
  logic [XLEN-1:0] IMEM_addr;
  logic            IMEM_gnt, IMEM_rvalid;
  logic [ILEN-1:0] IMEM_rdata;
  logic [ILEN-1:0] Inst;
  logic [XLEN-1:0] Inst_PC;
  logic            Inst_valid, Inst_ready;

  fetch_queue #(.XLEN(XLEN), .ILEN(ILEN), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST(RST), .PC(PC), .Valid(Valid), .Flush(Flush), .PC_stall(PC_stall),
    .IMEM_req(IMEM_req), .IMEM_addr(IMEM_addr), .IMEM_gnt(IMEM_gnt),
    .IMEM_rvalid(IMEM_rvalid), .IMEM_rdata(IMEM_rdata), .Inst(Inst), .Inst_PC(Inst_PC),
    .Inst_valid(Inst_valid), .Inst_ready(Inst_ready)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int tests = 0;
  int failed = 0;

  // Reference model: allocated entries (PCs), returned words, owed discards, skid slot.
  logic [31:0] mq_pc[$];
  logic [31:0] md[$];
  int          m_discard;
  bit          m_skid_v;
  logic [31:0] m_skid_pc;
  logic [31:0] g_pc;
  bit          g_valid;
  logic [31:0] mem_q[$];
  int          stall_cnt;
  logic [31:0] iss_q[$];
  logic [31:0] xfer_q[$];
  logic        obs_req, obs_stall, obs_iv;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] get(input logic [31:0] q[$], input int i);
    if (i < q.size()) return q[i];
    else return 32'hBAD0_BAD1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic cycle(input bit fl, input logic [31:0] tgt, input bit gnt, input bit rv, input bit rdy);
    bit src_v, e_req, e_issue, e_stall, e_iv, used;
    logic [31:0] src_pc;
    int pend;
    @(negedge CLK);
    Flush = fl; Valid = g_valid; PC = g_pc;
    IMEM_gnt = gnt; Inst_ready = rdy; IMEM_rvalid = rv;
    IMEM_rdata = (mem_q.size() > 0) ? mem_word(mem_q[0]) : $urandom();
    #1;
    src_v   = m_skid_v || g_valid;
    src_pc  = m_skid_v ? m_skid_pc : g_pc;
    e_req   = src_v && !fl && (mq_pc.size() + m_discard < DEPTH);
    e_issue = e_req && gnt;
    e_stall = !fl && src_v && !e_issue;
    e_iv    = !fl && (md.size() > 0);
    chk_b("imem_req", IMEM_req, e_req);
    chk_b("pc_stall", PC_stall, e_stall);
    chk_b("inst_valid", Inst_valid, e_iv);
    if (e_req) chk("imem_addr", IMEM_addr, src_pc);
    if (e_iv) begin
      chk("inst", Inst, md[0]);
      chk("inst_pc", Inst_PC, mq_pc[0]);
    end
    obs_req = IMEM_req; obs_stall = PC_stall; obs_iv = Inst_valid;
    if (PC_stall === 1'b1) stall_cnt++;
    if (IMEM_req === 1'b1 && gnt) iss_q.push_back(IMEM_addr);
    if (Inst_valid === 1'b1 && rdy) xfer_q.push_back(Inst_PC);
    // Model state at the coming edge.
    pend = mq_pc.size() - md.size();
    if (fl) begin
      used = rv && (m_discard > 0 || pend > 0);
      m_discard = m_discard + pend - int'(used);
      mq_pc.delete(); md.delete();
      m_skid_v = 1'b0;
    end else begin
      if (e_iv && rdy) begin
        void'(mq_pc.pop_front());
        void'(md.pop_front());
      end
      if (rv) begin
        if (m_discard > 0) m_discard--;
        else if (pend > 0) md.push_back(IMEM_rdata);
      end
      if (e_issue) mq_pc.push_back(src_pc);
      if (m_skid_v && !e_issue) begin
        m_skid_v = 1'b1;
      end else if (g_valid && !(e_issue && !m_skid_v)) begin
        m_skid_v = 1'b1; m_skid_pc = g_pc;
      end else begin
        m_skid_v = 1'b0;
      end
    end
    if (rv && mem_q.size() > 0) void'(mem_q.pop_front());
    if (e_issue) mem_q.push_back(src_pc);
    if (fl) begin
      g_pc = tgt; g_valid = 1'b1;
    end else begin
      if (g_valid) g_pc = g_pc + 32'd4;
      g_valid = !e_stall;
    end
    @(posedge CLK);
  endtask

  task automatic run(input int n, input bit gnt, input bit rv, input bit rdy);
    for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, gnt, rv, rdy);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1; Valid = 1'b1; PC = 32'h0000_1230; Flush = 1'b0;
    IMEM_gnt = 1'b1; IMEM_rvalid = 1'b1; IMEM_rdata = $urandom(); Inst_ready = 1'b1;
    #1;
    chk_b("rst_req", IMEM_req, 1'b0);
    chk_b("rst_stall", PC_stall, 1'b0);
    chk_b("rst_iv", Inst_valid, 1'b0);
    @(posedge CLK);
    #1;
    chk_b("rst_req_held", IMEM_req, 1'b0);
    chk_b("rst_iv_held", Inst_valid, 1'b0);
    chk("rst_inst_pc", Inst_PC, 32'h0);
    @(negedge CLK);
    RST = 1'b0; Valid = 1'b0; IMEM_gnt = 1'b0; IMEM_rvalid = 1'b0;
    mq_pc.delete(); md.delete(); mem_q.delete();
    m_discard = 0; m_skid_v = 1'b0; m_skid_pc = 32'h0;
    g_pc = 32'h0; g_valid = 1'b1;
    stall_cnt = 0; iss_q.delete(); xfer_q.delete();
  endtask

  initial begin
    RST = 1'b1; Valid = 1'b0; PC = 32'h0; Flush = 1'b0;
    IMEM_gnt = 1'b0; IMEM_rvalid = 1'b0; IMEM_rdata = 32'h0; Inst_ready = 1'b0;
    do_reset();

    // T1: streaming, one-cycle memory latency
    run(12, 1'b1, 1'b1, 1'b1);
    chk("t1_no_stall", stall_cnt, 32'd0);
    chk("t1_pc0", get(xfer_q, 0), 32'h0);
    chk("t1_pc1", get(xfer_q, 1), 32'h4);
    chk("t1_pc2", get(xfer_q, 2), 32'h8);

    // T2: grant withheld three cycles at 0x10
    cycle(1'b1, 32'h10, 1'b0, 1'b1, 1'b1);
    stall_cnt = 0;
    run(3, 1'b0, 1'b1, 1'b1);
    chk("t2_stall_cycles", stall_cnt, 32'd3);
    iss_q.delete();
    run(6, 1'b1, 1'b1, 1'b1);
    chk("t2_issue0", get(iss_q, 0), 32'h10);
    chk("t2_issue1", get(iss_q, 1), 32'h14);

    // T3: decode blocked until the queue fills, then drained
    cycle(1'b1, 32'h40, 1'b0, 1'b1, 1'b1);
    run(4, 1'b0, 1'b1, 1'b1);
    iss_q.delete(); xfer_q.delete();
    run(8, 1'b1, 1'b1, 1'b0);
    chk("t3_issues", iss_q.size(), 32'd4);
    chk_b("t3_req_off", obs_req, 1'b0);
    chk_b("t3_stall_on", obs_stall, 1'b1);
    iss_q.delete();
    run(10, 1'b1, 1'b1, 1'b1);
    chk("t3_drain_first", get(xfer_q, 0), 32'h40);
    chk_b("t3_drained", xfer_q.size() >= 4, 1'b1);
    chk_b("t3_resumed", iss_q.size() > 0, 1'b1);

    // T4: flush with requests outstanding
    cycle(1'b1, 32'h80, 1'b0, 1'b1, 1'b1);
    run(4, 1'b0, 1'b1, 1'b1);
    run(3, 1'b1, 1'b0, 1'b1);
    cycle(1'b1, 32'h100, 1'b0, 1'b0, 1'b1);
    xfer_q.delete();
    run(12, 1'b1, 1'b1, 1'b1);
    chk("t4_first_after_flush", get(xfer_q, 0), 32'h100);

    // T5: flush coincides with rvalid and a would-be pop
    cycle(1'b1, 32'h180, 1'b0, 1'b1, 1'b1);
    run(4, 1'b0, 1'b1, 1'b1);
    run(4, 1'b1, 1'b1, 1'b0);
    cycle(1'b1, 32'h200, 1'b1, 1'b1, 1'b1);
    chk_b("t5_iv_low", obs_iv, 1'b0);
    xfer_q.delete();
    run(12, 1'b1, 1'b1, 1'b1);
    chk("t5_first_after_flush", get(xfer_q, 0), 32'h200);

    // T6: reset while full with requests in flight, stray rvalid afterwards
    run(6, 1'b1, 1'b0, 1'b0);
    do_reset();
    cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    xfer_q.delete();
    run(10, 1'b1, 1'b1, 1'b1);
    chk("t6_first", get(xfer_q, 0), 32'h0);
    chk("t6_second", get(xfer_q, 1), 32'h4);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 15) == 0, $urandom() & 32'hFFFF_FFFC,
            $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 6);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
